// File: rtl/qam16_sym_checker_if.sv
// qam16_sym_checker_if: symbol-rate receive samples, tx reference and checker status bundle
interface qam16_sym_checker_if #(parameter int WIN_LEN_LOG2 = 12);
  logic                     clk_en;
  logic signed [17:0]       in_phs_sig;
  logic signed [17:0]       quad_sig;
  logic signed [17:0]       ref_level;
  logic [3:0]               tx_sym;
  logic [3:0]               sym_out;
  logic                     locked;
  logic [3:0]               delay_sel;
  logic                     sym_err;
  logic [WIN_LEN_LOG2:0]    err_count;
  logic                     window_done;
  modport master (
    output clk_en, in_phs_sig, quad_sig, ref_level, tx_sym,
    input  sym_out, locked, delay_sel, sym_err, err_count, window_done
  );
  modport slave (
    input  clk_en, in_phs_sig, quad_sig, ref_level, tx_sym,
    output sym_out, locked, delay_sel, sym_err, err_count, window_done
  );
endinterface

// File: rtl/qam16_sym_checker.sv
// qam16_sym_checker: 16-QAM slicer with channel-delay search, lock and windowed symbol-error counting
module qam16_sym_checker #(
  parameter int MAX_DELAY      = 15,
  parameter int TRIAL_LEN_LOG2 = 6,
  parameter int LOCK_ERR_MAX   = 2,
  parameter int WIN_LEN_LOG2   = 12,
  parameter int UNLOCK_ERR_MAX = 512
) (
  input logic clk,
  input logic reset,
  qam16_sym_checker_if.slave bus
);
  localparam int TW = TRIAL_LEN_LOG2 + 1;
  localparam int WW = WIN_LEN_LOG2 + 1;
  localparam logic [TW-1:0] TRIAL_SAT  = TW'(2**TRIAL_LEN_LOG2);
  localparam logic [TW-1:0] LOCK_MAX   = TW'(LOCK_ERR_MAX);
  localparam logic [WW-1:0] WIN_SAT    = WW'(2**WIN_LEN_LOG2);
  localparam logic [WW-1:0] UNLOCK_MAX = WW'(UNLOCK_ERR_MAX);
  localparam logic [3:0]    DMAX       = 4'(MAX_DELAY);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t                      state_q, state_d;
  logic [3:0]                  sym_out_q, sym_out_d;
  logic [MAX_DELAY:0][3:0]     tap_q, tap_d;
  logic [3:0]                  delay_sel_q, delay_sel_d;
  logic                        sym_err_q, sym_err_d;
  logic [WW-1:0]               err_count_q, err_count_d;
  logic                        window_done_q, window_done_d;
  logic [TRIAL_LEN_LOG2-1:0]   trial_cnt_q, trial_cnt_d;
  logic [TW-1:0]               trial_err_q, trial_err_d;
  logic [WIN_LEN_LOG2-1:0]     win_cnt_q, win_cnt_d;
  logic [WW-1:0]               win_err_q, win_err_d;
  logic signed [18:0]          thr;
  logic                        mm;
  logic [TW-1:0]               trial_tot;
  logic [WW-1:0]               win_tot;
  logic [3:0]                  nxt_delay;

  function automatic logic [1:0] slice(input logic signed [17:0] x, input logic signed [18:0] t);
    logic signed [18:0] xe;
    xe = {x[17], x};
    return (xe >= t) ? 2'b11 : (xe >= 19'sd0) ? 2'b10 : (xe >= -t) ? 2'b01 : 2'b00;
  endfunction

  assign thr = (bus.ref_level <= 18'sd0) ? 19'sd0 : {bus.ref_level[17], bus.ref_level};

  // slice, shift the tx delay line, compare, and run the search/lock state machine on each enable
  always_comb begin
    state_d       = state_q;
    sym_out_d     = sym_out_q;
    tap_d         = tap_q;
    delay_sel_d   = delay_sel_q;
    sym_err_d     = sym_err_q;
    err_count_d   = err_count_q;
    window_done_d = 1'b0;
    trial_cnt_d   = trial_cnt_q;
    trial_err_d   = trial_err_q;
    win_cnt_d     = win_cnt_q;
    win_err_d     = win_err_q;
    mm            = sym_out_q != tap_q[delay_sel_q];
    trial_tot     = (trial_err_q == TRIAL_SAT) ? trial_err_q : trial_err_q + TW'(mm);
    win_tot       = (win_err_q == WIN_SAT) ? win_err_q : win_err_q + WW'(mm);
    nxt_delay     = (delay_sel_q == DMAX) ? 4'd0 : delay_sel_q + 4'd1;
    if (bus.clk_en) begin
      sym_out_d = {slice(bus.in_phs_sig, thr), slice(bus.quad_sig, thr)};
      tap_d     = {tap_q[MAX_DELAY-1:0], bus.tx_sym};
      sym_err_d = (state_q == LOCKED) && mm;
      if (state_q == SEARCH) begin
        trial_cnt_d = trial_cnt_q + 1'b1;
        trial_err_d = (&trial_cnt_q) ? '0 : trial_tot;
        if (&trial_cnt_q) begin
          state_d     = (trial_tot <= LOCK_MAX) ? LOCKED : SEARCH;
          delay_sel_d = (trial_tot <= LOCK_MAX) ? delay_sel_q : nxt_delay;
        end
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        win_err_d = (&win_cnt_q) ? '0 : win_tot;
        if (&win_cnt_q) begin
          err_count_d   = win_tot;
          window_done_d = 1'b1;
          state_d       = (win_tot > UNLOCK_MAX) ? SEARCH : LOCKED;
          delay_sel_d   = (win_tot > UNLOCK_MAX) ? nxt_delay : delay_sel_q;
        end
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      sym_out_q     <= '0;
      tap_q         <= '0;
      delay_sel_q   <= '0;
      sym_err_q     <= 1'b0;
      err_count_q   <= '0;
      window_done_q <= 1'b0;
      trial_cnt_q   <= '0;
      trial_err_q   <= '0;
      win_cnt_q     <= '0;
      win_err_q     <= '0;
    end else begin
      state_q       <= state_d;
      sym_out_q     <= sym_out_d;
      tap_q         <= tap_d;
      delay_sel_q   <= delay_sel_d;
      sym_err_q     <= sym_err_d;
      err_count_q   <= err_count_d;
      window_done_q <= window_done_d;
      trial_cnt_q   <= trial_cnt_d;
      trial_err_q   <= trial_err_d;
      win_cnt_q     <= win_cnt_d;
      win_err_q     <= win_err_d;
    end
  end

  assign bus.sym_out     = sym_out_q;
  assign bus.locked      = state_q == LOCKED;
  assign bus.delay_sel   = delay_sel_q;
  assign bus.sym_err     = sym_err_q;
  assign bus.err_count   = err_count_q;
  assign bus.window_done = window_done_q;
endmodule
